// File: rtl/axi_mem_responder.sv
// AXI4 slave memory responder: INCR write/read bursts into a byte-addressable internal RAM.
// One outstanding write and one outstanding read; the two channels run independently.
module axi_mem_responder #(
    parameter int unsigned C_AXI_WIDTH      = 64,
    parameter int unsigned C_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_MEM_SIZE       = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [2:0]                    s_axi_awsize,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_AXI_WIDTH-1:0]        s_axi_wdata,
    input  logic [C_AXI_WIDTH/8-1:0]      s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic [2:0]                    s_axi_arsize,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_AXI_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int BYTES = int'(C_AXI_WIDTH / 8);
    localparam int WORDS = int'(C_MEM_SIZE) / BYTES;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [2:0] SIZE = 3'(OFF_W);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic       {RIdle, RData} r_state_e;

    logic [C_AXI_WIDTH-1:0] r_mem [WORDS];

    // Upper/lower address bits alias or are ignored by design.
    logic w_unused_addr;
    assign w_unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    // ---------------- write channel ----------------
    w_state_e         r_wstate, w_wstate_nxt;
    logic [IDX_W-1:0] r_widx, w_widx_nxt;
    logic [7:0]       r_wlen, w_wlen_nxt, r_wbeat, w_wbeat_nxt;
    logic             r_wsize_ok, w_wsize_ok_nxt, r_werr, w_werr_nxt;
    logic             r_awready, r_wready, r_bvalid;
    logic [1:0]       r_bresp, w_bresp_nxt;
    logic             w_aw_hs, w_w_hs, w_b_hs, w_mem_we, w_wlast_beat;

    assign w_aw_hs      = r_awready & s_axi_awvalid;
    assign w_w_hs       = r_wready & s_axi_wvalid;
    assign w_b_hs       = r_bvalid & s_axi_bready;
    assign w_wlast_beat = (r_wbeat == r_wlen);

    always_comb begin
        w_wstate_nxt   = r_wstate;
        w_widx_nxt     = r_widx;
        w_wlen_nxt     = r_wlen;
        w_wbeat_nxt    = r_wbeat;
        w_wsize_ok_nxt = r_wsize_ok;
        w_werr_nxt     = r_werr;
        w_bresp_nxt    = r_bresp;
        w_mem_we       = 1'b0;
        unique case (r_wstate)
            WIdle: if (w_aw_hs) begin
                w_wstate_nxt   = WData;
                w_widx_nxt     = s_axi_awaddr[OFF_W +: IDX_W];
                w_wlen_nxt     = s_axi_awlen;
                w_wbeat_nxt    = 8'd0;
                w_wsize_ok_nxt = (s_axi_awsize == SIZE);
                w_werr_nxt     = 1'b0;
            end
            WData: if (w_w_hs) begin
                w_mem_we    = r_wsize_ok;
                w_widx_nxt  = r_widx + IDX_W'(1);
                w_wbeat_nxt = r_wbeat + 8'd1;
                w_werr_nxt  = r_werr | (s_axi_wlast != w_wlast_beat);
                // Burst length comes from awlen; wlast only feeds the error flag.
                if (w_wlast_beat) begin
                    w_wstate_nxt = WResp;
                    w_bresp_nxt  = (w_werr_nxt | !r_wsize_ok) ? 2'b10 : 2'b00;
                end
            end
            WResp: if (w_b_hs) begin
                w_wstate_nxt = WIdle;
                w_bresp_nxt  = 2'b00;
                w_werr_nxt   = 1'b0;
            end
            default: w_wstate_nxt = WIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate   <= WIdle;
            r_widx     <= '0;
            r_wlen     <= 8'd0;
            r_wbeat    <= 8'd0;
            r_wsize_ok <= 1'b0;
            r_werr     <= 1'b0;
            r_bresp    <= 2'b00;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
        end else begin
            r_wstate   <= w_wstate_nxt;
            r_widx     <= w_widx_nxt;
            r_wlen     <= w_wlen_nxt;
            r_wbeat    <= w_wbeat_nxt;
            r_wsize_ok <= w_wsize_ok_nxt;
            r_werr     <= w_werr_nxt;
            r_bresp    <= w_bresp_nxt;
            r_awready  <= (w_wstate_nxt == WIdle);
            r_wready   <= (w_wstate_nxt == WData);
            r_bvalid   <= (w_wstate_nxt == WResp);
        end
    end

    // RAM is never cleared; nonblocking writes give read-first collisions.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_e               r_rstate, w_rstate_nxt;
    logic [IDX_W-1:0]       r_ridx, w_ridx_nxt, w_rd_idx;
    logic [7:0]             r_rlen, w_rlen_nxt, r_rbeat, w_rbeat_nxt;
    logic                   r_arready, r_rvalid, w_rvalid_nxt, r_rlast, w_rlast_nxt;
    logic [1:0]             r_rresp, w_rresp_nxt;
    logic [C_AXI_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                   w_ar_hs, w_r_hs, w_rd_en;

    assign w_ar_hs = r_arready & s_axi_arvalid;
    assign w_r_hs  = r_rvalid & s_axi_rready;

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_ridx_nxt   = r_ridx;
        w_rlen_nxt   = r_rlen;
        w_rbeat_nxt  = r_rbeat;
        w_rvalid_nxt = r_rvalid;
        w_rlast_nxt  = r_rlast;
        w_rresp_nxt  = r_rresp;
        w_rd_en      = 1'b0;
        w_rd_idx     = r_ridx;
        unique case (r_rstate)
            RIdle: if (w_ar_hs) begin
                w_rstate_nxt = RData;
                w_rd_idx     = s_axi_araddr[OFF_W +: IDX_W];
                w_ridx_nxt   = w_rd_idx;
                w_rd_en      = 1'b1;
                w_rlen_nxt   = s_axi_arlen;
                w_rbeat_nxt  = 8'd0;
                w_rvalid_nxt = 1'b1;
                w_rlast_nxt  = (s_axi_arlen == 8'd0);
                w_rresp_nxt  = (s_axi_arsize == SIZE) ? 2'b00 : 2'b10;
            end
            RData: if (w_r_hs) begin
                if (r_rbeat == r_rlen) begin
                    w_rstate_nxt = RIdle;
                    w_rvalid_nxt = 1'b0;
                    w_rlast_nxt  = 1'b0;
                    w_rresp_nxt  = 2'b00;
                end else begin
                    w_rd_idx    = r_ridx + IDX_W'(1);
                    w_ridx_nxt  = w_rd_idx;
                    w_rd_en     = 1'b1;
                    w_rbeat_nxt = r_rbeat + 8'd1;
                    w_rlast_nxt = ((r_rbeat + 8'd1) == r_rlen);
                end
            end
            default: w_rstate_nxt = RIdle;
        endcase
        w_rdata_nxt = w_rd_en ? r_mem[w_rd_idx] : r_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate  <= RIdle;
            r_ridx    <= '0;
            r_rlen    <= 8'd0;
            r_rbeat   <= 8'd0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_arready <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_ridx    <= w_ridx_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rbeat   <= w_rbeat_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
            r_arready <= (w_rstate_nxt == RIdle);
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

endmodule
